// File: rtl/world_map_arbiter.sv
// Arbitrates the single-port world-map RAM between video pixel reads (priority) and bot lookups,
// with a starvation limit on bot reads. Define WORLD_MAP_ARB_STATS_EN to build the stat counters.
module world_map_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_pixel,
    input  logic              bot_req,
    input  logic [ADDR_W-1:0] bot_addr,
    output logic [DATA_W-1:0] bot_data,
    output logic              bot_ack,
    output logic              busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [7:0]        stat_forced,
    output logic [15:0]       stat_vid_stall
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_BOT  = 2'd2
    } tag_e;

    logic [ADDR_W-1:0] vid_last_q, vid_last_d;
    logic              vid_valid_q, vid_valid_d;
    logic              bot_pend_q, bot_pend_d;
    logic [ADDR_W-1:0] bot_addr_q, bot_addr_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    tag_e              tag_q, tag_d;
    logic [DATA_W-1:0] vid_pixel_q, vid_pixel_d;
    logic [DATA_W-1:0] bot_data_q, bot_data_d;
    logic              bot_ack_q, bot_ack_d;

    logic vid_pend_s;
    logic forced_s;
    logic gnt_vid_s;
    logic gnt_bot_s;
    logic busy_s;

    assign vid_pend_s = !vid_valid_q || (vid_addr != vid_last_q);
    assign forced_s   = bot_pend_q && (starve_cnt_q >= 8'(STARVE_LIMIT));
    assign busy_s     = bot_pend_q || (tag_q == TAG_BOT);

    // Grant selection: forced bot, then video, then idle-slot bot; nothing while in reset.
    always_comb begin
        gnt_vid_s = 1'b0;
        gnt_bot_s = 1'b0;
        if (sysreset) begin
            gnt_vid_s = 1'b0;
        end else if (forced_s) begin
            gnt_bot_s = 1'b1;
        end else if (vid_pend_s) begin
            gnt_vid_s = 1'b1;
        end else if (bot_pend_q) begin
            gnt_bot_s = 1'b1;
        end else begin
            gnt_bot_s = 1'b0;
        end
    end

    assign mem_en   = gnt_vid_s || gnt_bot_s;
    assign mem_addr = gnt_bot_s ? bot_addr_q : vid_addr;

    // Next-state: grant bookkeeping, request acceptance and capture of returning read data.
    always_comb begin
        vid_last_d   = vid_last_q;
        vid_valid_d  = vid_valid_q;
        bot_pend_d   = bot_pend_q;
        bot_addr_d   = bot_addr_q;
        starve_cnt_d = starve_cnt_q;
        tag_d        = TAG_NONE;
        vid_pixel_d  = vid_pixel_q;
        bot_data_d   = bot_data_q;
        bot_ack_d    = 1'b0;

        if (gnt_vid_s) begin
            vid_last_d  = vid_addr;
            vid_valid_d = 1'b1;
            tag_d       = TAG_VID;
            if (bot_pend_q && (starve_cnt_q != 8'hFF)) begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else if (gnt_bot_s) begin
            bot_pend_d   = 1'b0;
            starve_cnt_d = 8'd0;
            tag_d        = TAG_BOT;
        end else begin
            tag_d = TAG_NONE;
        end

        // A strobe arriving while busy is simply ignored.
        if (bot_req && !busy_s) begin
            bot_pend_d = 1'b1;
            bot_addr_d = bot_addr;
        end else begin
            bot_addr_d = bot_addr_q;
        end

        case (tag_q)
            TAG_VID: vid_pixel_d = mem_data;
            TAG_BOT: begin
                bot_data_d = mem_data;
                bot_ack_d  = 1'b1;
            end
            default: bot_ack_d = 1'b0;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            vid_last_q   <= '0;
            vid_valid_q  <= 1'b0;
            bot_pend_q   <= 1'b0;
            bot_addr_q   <= '0;
            starve_cnt_q <= 8'd0;
            tag_q        <= TAG_NONE;
            vid_pixel_q  <= '0;
            bot_data_q   <= '0;
            bot_ack_q    <= 1'b0;
        end else begin
            vid_last_q   <= vid_last_d;
            vid_valid_q  <= vid_valid_d;
            bot_pend_q   <= bot_pend_d;
            bot_addr_q   <= bot_addr_d;
            starve_cnt_q <= starve_cnt_d;
            tag_q        <= tag_d;
            vid_pixel_q  <= vid_pixel_d;
            bot_data_q   <= bot_data_d;
            bot_ack_q    <= bot_ack_d;
        end
    end

    assign vid_pixel = vid_pixel_q;
    assign bot_data  = bot_data_q;
    assign bot_ack   = bot_ack_q;
    assign busy      = busy_s;

`ifdef WORLD_MAP_ARB_STATS_EN
    logic [7:0]  stat_forced_q, stat_forced_d;
    logic [15:0] stat_vid_stall_q, stat_vid_stall_d;

    // Saturating counters of forced bot grants and video cycles lost to bot.
    always_comb begin
        stat_forced_d    = stat_forced_q;
        stat_vid_stall_d = stat_vid_stall_q;
        if (gnt_bot_s && forced_s && (stat_forced_q != 8'hFF)) begin
            stat_forced_d = stat_forced_q + 8'd1;
        end else begin
            stat_forced_d = stat_forced_q;
        end
        if (gnt_bot_s && vid_pend_s && (stat_vid_stall_q != 16'hFFFF)) begin
            stat_vid_stall_d = stat_vid_stall_q + 16'd1;
        end else begin
            stat_vid_stall_d = stat_vid_stall_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            stat_forced_q    <= 8'd0;
            stat_vid_stall_q <= 16'd0;
        end else begin
            stat_forced_q    <= stat_forced_d;
            stat_vid_stall_q <= stat_vid_stall_d;
        end
    end

    assign stat_forced    = stat_forced_q;
    assign stat_vid_stall = stat_vid_stall_q;
`else
    assign stat_forced    = 8'd0;
    assign stat_vid_stall = 16'd0;
`endif

endmodule

// File: tb/tb_world_map_arbiter.sv
// Randomized bench for world_map_arbiter against a transaction-level reference model,
// preceded by the directed scenarios (idle video, bot read, dropped strobe, starvation, reset, race).
module tb_world_map_arbiter;

    localparam int LIM = 8;

    logic        sysclk = 1'b0;
    logic        sysreset = 1'b1;
    logic [13:0] vid_addr = 14'h0000;
    logic [1:0]  vid_pixel;
    logic        bot_req = 1'b0;
    logic [13:0] bot_addr = 14'h0000;
    logic [1:0]  bot_data;
    logic        bot_ack;
    logic        busy;
    logic        mem_en;
    logic [13:0] mem_addr;
    logic [1:0]  mem_data = 2'b00;
    logic [7:0]  stat_forced;
    logic [15:0] stat_vid_stall;

    world_map_arbiter #(.ADDR_W(14), .DATA_W(2), .STARVE_LIMIT(LIM)) dut (
        .sysclk(sysclk), .sysreset(sysreset), .vid_addr(vid_addr), .vid_pixel(vid_pixel),
        .bot_req(bot_req), .bot_addr(bot_addr), .bot_data(bot_data), .bot_ack(bot_ack),
        .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .stat_forced(stat_forced), .stat_vid_stall(stat_vid_stall)
    );

    always #5 sysclk = ~sysclk;

    logic [1:0] mem_arr [0:16383];

    // Block RAM stand-in: one cycle of read latency.
    always @(posedge sysclk) begin
        if (mem_en) mem_data <= mem_arr[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int n_acks   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the memory this cycle and what lands when.
    bit         m_known = 1'b0;
    int         m_last  = -1;   // last video address read, -1 = none since reset
    int         m_pend  = -1;   // waiting bot address, -1 = none
    int         m_lost  = 0;    // cycles the waiting bot read lost to video
    int         m_fly   = 0;    // 0 none, 1 video, 2 bot read in flight
    int         m_fly_a = 0;
    logic [1:0] m_pix   = 2'b00;
    logic [1:0] m_bdat  = 2'b00;
    bit         m_ack   = 1'b0;
    int         m_sf    = 0;
    int         m_stall = 0;

    task automatic step(input bit rst, input logic [13:0] va, input bit req, input logic [13:0] ba);
        int  g;
        bit  vp;
        bit  m_busy;
        bit  forced;
        @(posedge sysclk);
        #1;
        sysreset = rst;
        vid_addr = va;
        bot_req  = req;
        bot_addr = ba;
        @(negedge sysclk);
        m_busy = (m_pend >= 0) || (m_fly == 2);
        if (m_known) begin
            check_eq("vid_pixel", 32'(vid_pixel), 32'(m_pix));
            check_eq("bot_data", 32'(bot_data), 32'(m_bdat));
            check_eq("bot_ack", 32'(bot_ack), 32'(m_ack));
            check_eq("busy", 32'(busy), 32'(m_busy));
            check_eq("stat_forced", 32'(stat_forced), 32'(m_sf));
            check_eq("stat_vid_stall", 32'(stat_vid_stall), 32'(m_stall));
        end
        if (bot_ack === 1'b1) n_acks++;
        if (rst) begin
            check_eq("mem_en_rst", 32'(mem_en), 32'd0);
            m_known = 1'b1;
            m_last = -1; m_pend = -1; m_lost = 0; m_fly = 0;
            m_pix = 2'b00; m_bdat = 2'b00; m_ack = 1'b0; m_sf = 0; m_stall = 0;
        end else begin
            vp     = (m_last < 0) || (int'(va) != m_last);
            forced = (m_pend >= 0) && (m_lost >= LIM);
            if (forced)           g = 2;
            else if (vp)          g = 1;
            else if (m_pend >= 0) g = 2;
            else                  g = 0;
            check_eq("mem_en", 32'(mem_en), 32'(g != 0));
            if (g != 0) check_eq("mem_addr", 32'(mem_addr), (g == 1) ? 32'(va) : 32'(m_pend));
            // Data returning from last cycle's read.
            m_ack = 1'b0;
            if (m_fly == 1) m_pix = mem_arr[m_fly_a];
            if (m_fly == 2) begin
                m_bdat = mem_arr[m_fly_a];
                m_ack  = 1'b1;
            end
`ifdef WORLD_MAP_ARB_STATS_EN
            if (g == 2 && forced && m_sf < 255) m_sf++;
            if (g == 2 && vp && m_stall < 65535) m_stall++;
`endif
            m_fly   = g;
            m_fly_a = (g == 1) ? int'(va) : m_pend;
            if (g == 1) begin
                m_last = int'(va);
                if (m_pend >= 0 && m_lost < 255) m_lost++;
            end
            if (g == 2) begin
                m_pend = -1;
                m_lost = 0;
            end
            if (req && !m_busy) m_pend = int'(ba);
        end
    endtask

    logic [13:0] cur_va;
    int          acks_before;

    initial begin
        for (int i = 0; i < 16384; i++) mem_arr[i] = 2'($urandom);
        mem_arr[14'h0123] = 2'b10;
        mem_arr[14'h1F00] = 2'b01;
        mem_arr[14'h0200] = 2'b11;
        mem_arr[14'h0201] = 2'b00;

        // Reset then idle video.
        cur_va = 14'h0123;
        for (int i = 0; i < 3; i++) step(1'b1, cur_va, 1'b0, 14'h0000);
        for (int i = 0; i < 5; i++) step(1'b0, cur_va, 1'b0, 14'h0000);
        check_eq("idle_pixel", 32'(vid_pixel), 32'h2);

        // Bot read, then a strobe during busy that must be dropped.
        acks_before = n_acks;
        step(1'b0, cur_va, 1'b1, 14'h1F00);
        step(1'b0, cur_va, 1'b1, 14'h0ABC);
        for (int i = 0; i < 6; i++) step(1'b0, cur_va, 1'b0, 14'h0000);
        check_eq("single_ack", 32'(n_acks - acks_before), 32'd1);
        check_eq("bot_read_data", 32'(bot_data), 32'h1);

        // Starvation under continuous video change.
        acks_before = n_acks;
        for (int i = 0; i < 16; i++) begin
            cur_va = cur_va + 14'd1;
            step(1'b0, cur_va, (i == 0), 14'h1F00);
        end
        check_eq("starve_ack", 32'(n_acks - acks_before), 32'd1);

        // Reset in the cycle after a bot grant.
        acks_before = n_acks;
        step(1'b0, cur_va, 1'b1, 14'h0321);
        step(1'b0, cur_va, 1'b0, 14'h0000);
        step(1'b1, cur_va, 1'b0, 14'h0000);
        for (int i = 0; i < 5; i++) step(1'b0, cur_va, 1'b0, 14'h0000);
        check_eq("rst_no_ack", 32'(n_acks - acks_before), 32'd0);

        // Video address race.
        step(1'b0, 14'h0200, 1'b0, 14'h0000);
        step(1'b0, 14'h0201, 1'b0, 14'h0000);
        step(1'b0, 14'h0201, 1'b0, 14'h0000);
        check_eq("race_a", 32'(vid_pixel), 32'h3);
        step(1'b0, 14'h0201, 1'b0, 14'h0000);
        check_eq("race_b", 32'(vid_pixel), 32'h0);
        cur_va = 14'h0201;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      cur_va = 14'($urandom);
            else if (r < 6) cur_va = cur_va + 14'd1;
            step(($urandom_range(0, 499) == 0), cur_va, ($urandom_range(0, 3) == 0), 14'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/world_map_arbiter.md
# world_map_arbiter

Shares the single-port world-map memory between the VGA video path and the bot's sensor/location lookups. Video reads have priority and are issued only when the downscaled pixel address changes. Bot reads use a strobe/ack handshake and fill the idle slots in between. A starvation limit guarantees that bot lookups complete even under continuous video traffic. The block sits between the bot's map-read logic, the video pixel path and the map block RAM.

## Interface
Parameters:
- ADDR_W, 14, map address width ({row[6:0], col[6:0]}).
- DATA_W, 2, map pixel width.
- STARVE_LIMIT, 8, number of cycles a pending bot read may lose to video before it is forced through; legal range 1..255.

Ports:
- sysclk  in  1  system clock.
- sysreset  in  1  synchronous reset, active-high.
- vid_addr  in  ADDR_W  current video map address, held stable or changing freely.
- vid_pixel  out  DATA_W  map pixel for the most recently serviced vid_addr.
- bot_req  in  1  one-cycle read strobe; accepted only while busy=0.
- bot_addr  in  ADDR_W  bot read address, sampled with bot_req.
- bot_data  out  DATA_W  bot read result, valid while bot_ack=1 and held afterwards.
- bot_ack  out  1  one-cycle completion pulse.
- busy  out  1  bot read accepted and not yet acknowledged.
- mem_en  out  1  memory read enable (combinational grant).
- mem_addr  out  ADDR_W  memory address (combinational).
- mem_data  in  DATA_W  memory read data, valid one cycle after mem_en.
- stat_forced  out  8  count of forced bot grants, saturating at 255.
- stat_vid_stall  out  16  count of cycles video was pending but not granted, saturating at 65535.

## Operation
- Registers: vid_last, vid_valid, bot_pend, bot_addr_q, starve_cnt, tag (NONE/VID/BOT), vid_pixel, bot_data, bot_ack.
- Video pending: vid_valid=0, or vid_addr != vid_last.
- Grant rule, evaluated once per cycle:
  - Bot is granted if bot_pend=1 and starve_cnt >= STARVE_LIMIT (forced).
  - Otherwise video is granted if video is pending.
  - Otherwise bot is granted if bot_pend=1.
  - Otherwise no grant.
- On a video grant: mem_en=1, mem_addr=vid_addr. At the clock edge, vid_last<=vid_addr, vid_valid<=1, tag<=VID.
- On a bot grant: mem_en=1, mem_addr=bot_addr_q. At the clock edge, bot_pend<=0, starve_cnt<=0, tag<=BOT.
- Starvation counter: starve_cnt increments, saturating, on each cycle with bot_pend=1 and a video grant.
- Capture stage:
  - tag=VID: vid_pixel<=mem_data.
  - tag=BOT: bot_data<=mem_data and bot_ack<=1; busy drops in the same cycle that bot_ack rises.
  - tag=NONE: no capture.
- bot_req with busy=1 is dropped silently: no ack and no state change.
- busy = bot_pend | (tag==BOT).
- vid_addr changing while a video read is in flight: the new address is pending the next cycle, and both results land in order.
- vid_addr changing during a forced bot cycle: video is serviced the following cycle with the latest vid_addr. Intermediate addresses are never read.

## Timing
- Video: vid_addr changes in cycle t and is granted in cycle t; the new vid_pixel is visible in cycle t+2. If preempted by a forced bot read, the update is visible at t+3.
- Bot, minimum latency: bot_req in cycle t → grant at t+1 → bot_ack and bot_data at t+3. The next bot_req is accepted at t+3 (busy=0 in that cycle).
- Bot, worst case under constant video change: ack arrives within STARVE_LIMIT+3 cycles of the request.
- Reset values (all synchronous):
  - vid_pixel=0, bot_data=0, bot_ack=0, busy=0.
  - vid_valid=0, bot_pend=0, tag=NONE, starve_cnt=0.
  - stat_forced=0, stat_vid_stall=0.
  - mem_en=0 while sysreset=1.
- Reset mid-operation: any in-flight read is discarded and no bot_ack is issued. The first cycle after reset always issues a video read, because vid_valid=0.

## Configuration
- WORLD_MAP_ARB_STATS_EN defined: stat_forced and stat_vid_stall are implemented as described.
  - stat_forced increments on each forced bot grant.
  - stat_vid_stall increments on each cycle with video pending and the grant going to bot.
- Undefined: both stat outputs are tied to 0 and no counter logic is built. Arbitration behaviour is identical either way.

## Test plan
- Reset then idle: after sysreset, vid_addr=14'h0123 and mem_data returns 2'b10 → mem_en pulses once, vid_pixel=2'b10 two cycles later, then mem_en stays 0 while vid_addr is stable.
- Bot read on quiet video: vid_addr stable, bot_req with bot_addr=14'h1F00 and memory returning 2'b01 → mem_addr=14'h1F00 at t+1, bot_ack=1 with bot_data=2'b01 at t+3, busy high for t+1..t+2.
- Dropped request: a second bot_req at t+1 during a busy read → exactly one bot_ack, and no mem_addr equal to the second address ever appears.
- Starvation: vid_addr increments every cycle, bot_req at t, STARVE_LIMIT=8 → bot grant at t+9, bot_ack at t+11; stat_forced=1 and stat_vid_stall=1 with the stats macro enabled, and both 0 without it.
- Reset mid-read: sysreset asserted in the cycle after a bot grant → no bot_ack ever appears, busy=0, bot_data=0.
- Address race: vid_addr A in cycle t, B in t+1 (memory A→2'b11, B→2'b00) → vid_pixel=2'b11 at t+2 and 2'b00 at t+3.
